// File: rtl/arb4_32b_rr.sv
// Four-requester round-robin arbiter feeding a single-entry 32-bit output buffer.
// The winner is chosen combinationally from a rotating priority pointer; the
// winning message is muxed and registered so the response side is fully registered.
module arb4_32b_rr #(
    parameter int NBITS = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       req_val,
    output logic [3:0]       req_rdy,
    input  logic [NBITS-1:0] req_msg0,
    input  logic [NBITS-1:0] req_msg1,
    input  logic [NBITS-1:0] req_msg2,
    input  logic [NBITS-1:0] req_msg3,
    output logic             resp_val,
    input  logic             resp_rdy,
    output logic [NBITS-1:0] resp_msg,
    output logic [1:0]       resp_id
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t           state_q;
    state_t           state_d;
    logic [1:0]       ptr_q;
    logic [3:0]       rot_val;
    logic [3:0]       rot_gnt;
    logic [3:0]       gnt;
    logic [1:0]       win_off;
    logic [1:0]       win;
    logic             space;
    logic             accept;
    logic [NBITS-1:0] msg_p0;

    // Rotate requests so that position 0 is the current highest-priority requester.
    always_comb begin
        rot_val = '0;
        for (int k = 0; k < 4; k++) begin
            rot_val[k] = req_val[ptr_q + 2'(k)];
        end
    end

    // Fixed priority in rotated space, built from gates so an X request stays X.
    assign rot_gnt[0] = rot_val[0];
    assign rot_gnt[1] = ~rot_val[0] & rot_val[1];
    assign rot_gnt[2] = ~rot_val[0] & ~rot_val[1] & rot_val[2];
    assign rot_gnt[3] = ~rot_val[0] & ~rot_val[1] & ~rot_val[2] & rot_val[3];

    assign win_off = {rot_gnt[2] | rot_gnt[3], rot_gnt[1] | rot_gnt[3]};
    assign win     = ptr_q + win_off;

    // Rotate the one-hot grant back into requester order.
    always_comb begin
        gnt = '0;
        for (int k = 0; k < 4; k++) begin
            gnt[ptr_q + 2'(k)] = rot_gnt[k];
        end
    end

    // The buffer can take a message when empty or when it is draining this cycle.
    assign space    = (state_q == EMPTY) | resp_rdy;
    assign req_rdy  = gnt & {4{space & rst_n}};
    assign accept   = |req_rdy;
    assign resp_val = (state_q == FULL);

    // 4:1 message mux steered only by the winner, so other requesters' data never leaks.
    always_comb begin
        case (win)
            2'd0:    msg_p0 = req_msg0;
            2'd1:    msg_p0 = req_msg1;
            2'd2:    msg_p0 = req_msg2;
            2'd3:    msg_p0 = req_msg3;
            default: msg_p0 = '0;
        endcase
    end

    // Buffer next-state: fill on accept, empty on a drain with no refill.
    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY:   if (accept) state_d = FULL;
            FULL:    if (resp_rdy && !accept) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    // Buffer state and round-robin pointer; the pointer moves only on an accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            ptr_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            if (accept) ptr_q <= win + 2'd1;
        end
    end

    // ---- stage p0 -> p1: capture the winning message and its source id ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_msg <= '0;
            resp_id  <= 2'd0;
        end else if (accept) begin
            resp_msg <= msg_p0;
            resp_id  <= win;
        end
    end

endmodule

// File: tb/tb_arb4_32b_rr.sv
module tb_arb4_32b_rr;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_val;
    logic [3:0]  req_rdy;
    logic [31:0] req_msg0, req_msg1, req_msg2, req_msg3;
    logic        resp_val;
    logic        resp_rdy;
    logic [31:0] resp_msg;
    logic [1:0]  resp_id;

    int checks = 0;
    int errors = 0;

    arb4_32b_rr #(.NBITS(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_val  (req_val),
        .req_rdy  (req_rdy),
        .req_msg0 (req_msg0),
        .req_msg1 (req_msg1),
        .req_msg2 (req_msg2),
        .req_msg3 (req_msg3),
        .resp_val (resp_val),
        .resp_rdy (resp_rdy),
        .resp_msg (resp_msg),
        .resp_id  (resp_id)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Check the full registered response.
    task automatic check_resp(input string tag, input logic v, input logic [31:0] m, input logic [1:0] id);
        check({tag, "_val"}, {31'd0, resp_val}, {31'd0, v});
        check({tag, "_msg"}, resp_msg, m);
        check({tag, "_id"},  {30'd0, resp_id}, {30'd0, id});
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n    = 1'b1;
        req_val  = 4'b1111;
        resp_rdy = 1'b0;
        req_msg0 = 32'hA000_0000;
        req_msg1 = 32'hA000_0001;
        req_msg2 = 32'hA000_0002;
        req_msg3 = 32'hA000_0003;
        #2 rst_n = 1'b0;
        #1;
        // Reset defaults with all requesters asserting.
        check("rst_rdy", {28'd0, req_rdy}, 32'h0);
        check_resp("rst", 1'b0, 32'h0, 2'd0);
        tick();
        tick();
        check("rst_rdy_hold", {28'd0, req_rdy}, 32'h0);

        // Release reset; fairness run with all four requesting.
        rst_n    = 1'b1;
        resp_rdy = 1'b1;
        #1 check("rr_g0_rdy", {28'd0, req_rdy}, 32'h1);
        tick(); check_resp("rr0", 1'b1, 32'hA000_0000, 2'd0);
        check("rr_g1_rdy", {28'd0, req_rdy}, 32'h2);
        tick(); check_resp("rr1", 1'b1, 32'hA000_0001, 2'd1);
        check("rr_g2_rdy", {28'd0, req_rdy}, 32'h4);
        tick(); check_resp("rr2", 1'b1, 32'hA000_0002, 2'd2);
        check("rr_g3_rdy", {28'd0, req_rdy}, 32'h8);
        tick(); check_resp("rr3", 1'b1, 32'hA000_0003, 2'd3);
        check("rr_g4_rdy", {28'd0, req_rdy}, 32'h1);
        tick(); check_resp("rr4", 1'b1, 32'hA000_0000, 2'd0);

        // Single requester 2 (pointer is 1).
        req_val  = 4'b0100;
        req_msg2 = 32'h1234_5678;
        #1 check("single_rdy", {28'd0, req_rdy}, 32'h4);
        tick(); check_resp("single", 1'b1, 32'h1234_5678, 2'd2);
        req_msg2 = 32'hA000_0002;

        // Pointer is 3: wrap to 0 then 1 then 0, skipping idle requesters.
        req_val = 4'b0011;
        #1 check("wrap_rdy0", {28'd0, req_rdy}, 32'h1);
        tick(); check_resp("wrap0", 1'b1, 32'hA000_0000, 2'd0);
        check("wrap_rdy1", {28'd0, req_rdy}, 32'h2);
        tick(); check_resp("wrap1", 1'b1, 32'hA000_0001, 2'd1);
        check("wrap_rdy2", {28'd0, req_rdy}, 32'h1);
        tick(); check_resp("wrap2", 1'b1, 32'hA000_0000, 2'd0);

        // X on a non-requesting bit flows into req_rdy (pointer is 1, bit 0 last in line).
        req_val = 4'b00x0;
        #1 check("xval_rdy", {28'd0, req_rdy}, {28'd0, 4'b00x0});

        // Requests withdrawn: buffer drains, pointer holds at 1.
        req_val = 4'b0000;
        #1 check("idle_rdy", {28'd0, req_rdy}, 32'h0);
        tick(); check("drain_val", {31'd0, resp_val}, 32'h0);
        check("drain_msg_hold", resp_msg, 32'hA000_0000);

        // Fill with DEADBEEF from requester 1.
        req_msg1 = 32'hDEAD_BEEF;
        req_val  = 4'b0010;
        #1 check("fill_rdy", {28'd0, req_rdy}, 32'h2);
        tick(); check_resp("fill", 1'b1, 32'hDEAD_BEEF, 2'd1);

        // Backpressure for three cycles with everyone requesting.
        resp_rdy = 1'b0;
        req_val  = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            #1 check("bp_rdy", {28'd0, req_rdy}, 32'h0);
            tick(); check_resp("bp", 1'b1, 32'hDEAD_BEEF, 2'd1);
        end

        // Release: drain and accept in one edge, next winner is 2.
        resp_rdy = 1'b1;
        #1 check("b2b_rdy", {28'd0, req_rdy}, 32'h4);
        tick(); check_resp("b2b", 1'b1, 32'hA000_0002, 2'd2);

        // Pointer 3, only requester 1 valid: load resp_id=1 and pointer becomes 2.
        req_val = 4'b0010;
        #1 check("pre_rst_rdy", {28'd0, req_rdy}, 32'h2);
        tick(); check_resp("pre_rst", 1'b1, 32'hDEAD_BEEF, 2'd1);

        // Asynchronous reset between edges discards the buffer.
        resp_rdy = 1'b0;
        req_val  = 4'b1111;
        #2 rst_n = 1'b0;
        #1 check_resp("mid_rst", 1'b0, 32'h0, 2'd0);
        check("mid_rst_rdy", {28'd0, req_rdy}, 32'h0);
        tick();

        // After release the first grant goes to 0; X on requester 3 data stays out.
        rst_n    = 1'b1;
        resp_rdy = 1'b1;
        req_val  = 4'b0001;
        req_msg3 = 'x;
        #1 check("post_rst_rdy", {28'd0, req_rdy}, 32'h1);
        req_val = 4'b1111;
        #1 check("post_rst_rdy_all", {28'd0, req_rdy}, 32'h1);
        tick(); check_resp("post_rst", 1'b1, 32'hA000_0000, 2'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Safety net so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
